// File: rtl/fp32_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_serial_pkg
// Description : Shared constants and state encodings for the fp32 serial host.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_serial_pkg;

    localparam int FP32_W          = 32;
    localparam int DEFAULT_TIMEOUT = 60;

    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_SEND_A = 3'd2;
    localparam logic [2:0] ST_SEND_B = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/fp32_sipo_capture.sv
`default_nettype none
// ============================================================================
// Module      : fp32_sipo_capture
// Description : Serial-in shift register; exposes the value it takes this edge.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_sipo_capture
    import fp32_serial_pkg::*;
#(
    parameter int WORD_W = FP32_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_shift_en,
    input  logic              i_din,
    output logic [WORD_W-1:0] o_next
);

    logic [WORD_W-1:0] r_q;
    logic [WORD_W-1:0] w_base;

    // Clear and shift may coincide: the shifted bit lands in a cleared word.
    always_comb begin
        w_base = i_clr ? '0 : r_q;
        o_next = i_shift_en ? {w_base[WORD_W-2:0], i_din} : w_base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= o_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp32_serial_host.sv
`default_nettype none
// ============================================================================
// Module      : fp32_serial_host
// Description : Parallel-to-serial host for add_float; optional WAIT watchdog
//               enabled by FP32_SERIAL_HOST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_serial_host
    import fp32_serial_pkg::*;
#(
    parameter int WORD_W  = FP32_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    output logic              busy,
    output logic              go,
    output logic              inpab,
    input  logic              shift,
    input  logic              out_c,
    input  logic              over,
    input  logic              under,
    input  logic              done,
    output logic [WORD_W-1:0] result,
    output logic              res_over,
    output logic              res_under,
    output logic              res_valid,
    output logic              timeout_err
);

    localparam logic [5:0] c_LAST_BIT = 6'(WORD_W - 1);
    localparam int         c_OP_MSB   = 2 * WORD_W - 1;

    logic [2:0]          r_state;
    logic [5:0]          r_bit_cnt;
    logic [c_OP_MSB:0]   r_op;
    logic                r_go;
    logic                r_inpab;
    logic [WORD_W-1:0]   r_result;
    logic                r_res_over;
    logic                r_res_under;
    logic                r_res_valid;
    logic                w_capturing;
    logic [WORD_W-1:0]   w_cap_next;
    logic                w_expire;

    assign w_capturing = (r_state == ST_ARM) || (r_state == ST_SEND_A) ||
                         (r_state == ST_SEND_B) || (r_state == ST_WAIT);

    fp32_sipo_capture #(
        .WORD_W (WORD_W)
    ) u_capture (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (r_state == ST_ARM),
        .i_shift_en (w_capturing && shift),
        .i_din      (out_c),
        .o_next     (w_cap_next)
    );

`ifdef FP32_SERIAL_HOST_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_timeout_err;

    // done on the expiry cycle takes priority over the watchdog.
    assign w_expire = (r_state == ST_WAIT) && !done &&
                      (r_wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_expire;
            r_wait_cnt    <= ((r_state == ST_WAIT) && !w_expire) ? r_wait_cnt + 8'd1 : 8'd0;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 6'd0;
            r_op        <= '0;
            r_go        <= 1'b1;
            r_inpab     <= 1'b0;
            r_result    <= '0;
            r_res_over  <= 1'b0;
            r_res_under <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_go    <= 1'b1;
                    r_inpab <= 1'b0;
                    if (start) begin
                        r_op    <= {op_a, op_b};
                        r_go    <= 1'b0;
                        r_state <= ST_ARM;
                    end
                end
                // inpab is registered one edge ahead, so the A MSB leaves here.
                ST_ARM: begin
                    r_bit_cnt <= 6'd0;
                    r_inpab   <= r_op[c_OP_MSB];
                    r_op      <= r_op << 1;
                    r_state   <= ST_SEND_A;
                end
                ST_SEND_A: begin
                    r_inpab <= r_op[c_OP_MSB];
                    r_op    <= r_op << 1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_bit_cnt <= 6'd0;
                        r_state   <= ST_SEND_B;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                ST_SEND_B: begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_bit_cnt <= 6'd0;
                        r_inpab   <= 1'b0;
                        r_state   <= ST_WAIT;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        r_inpab   <= r_op[c_OP_MSB];
                        r_op      <= r_op << 1;
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        r_result    <= w_cap_next;
                        r_res_over  <= over;
                        r_res_under <= under;
                        r_res_valid <= 1'b1;
                        r_go        <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_expire) begin
                        r_go    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_go    <= 1'b1;
                    r_inpab <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign go        = r_go;
    assign inpab     = r_inpab;
    assign result    = r_result;
    assign res_over  = r_res_over;
    assign res_under = r_res_under;
    assign res_valid = r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp32_serial_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_serial_host
// Description : Scoreboard bench with an add_float stand-in for fp32_serial_host.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_serial_host;
    import fp32_serial_pkg::*;

`ifdef FP32_SERIAL_HOST_TIMEOUT_EN
    localparam int c_EXP_TIMEOUTS = 1;
`else
    localparam int c_EXP_TIMEOUTS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, shift, out_c, over, under, done;
    logic [31:0] op_a, op_b, result;
    logic        busy, go, inpab, res_over, res_under, res_valid, timeout_err;

    fp32_serial_host #(.WORD_W(32), .TIMEOUT(60)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .go(go), .inpab(inpab), .shift(shift), .out_c(out_c),
        .over(over), .under(under), .done(done), .result(result),
        .res_over(res_over), .res_under(res_under), .res_valid(res_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n_timeouts = 0;
    logic [64:0] op_q[$];          // {directed, a, b}
    logic [33:0] exp_q[$];         // {result, over, under}
    logic [31:0] last_result = 32'h0;
    bit          expect_abort = 1'b0;
    bit          suppress_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rbit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    // Known sums for the directed vectors; arbitrary words otherwise.
    function automatic void model_add(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] s, output logic ov, output logic un);
        if (a == 32'h7F7F_FFFF && b == 32'h7380_0000) begin
            s = FP32_POS_INF; ov = 1'b1; un = 1'b0;
        end else if (a == FP32_ONE && b == FP32_ONE) begin
            s = 32'h4000_0000; ov = 1'b0; un = 1'b0;
        end else begin
            s = $urandom; ov = rbit(); un = rbit();
        end
    endfunction

    // add_float stand-in: k counts negedges since go fell (k=1 is ARM).
    task automatic run_op();
        logic [64:0] op;
        logic [31:0] rword, expv;
        logic        rov, run;
        logic [63:0] seen;
        bit          q[$];
        int          nres, resp_start, done_k, k, idx, n;
        seen = '0;
        if (op_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_launch: go fell with no start issued");
            return;
        end
        op = op_q.pop_front();
        model_add(op[63:32], op[31:0], rword, rov, run);
        nres       = op[64] ? 32 : int'($urandom_range(26, 38));
        resp_start = 66 + int'($urandom_range(0, 4));
        done_k     = suppress_done ? 100000 : resp_start + nres - 1 + int'($urandom_range(0, 2));
        k = 1;
        forever begin
            if (go !== 1'b0 || busy !== 1'b1) begin
                shift = 0; out_c = 0; done = 0;
                if (!expect_abort) begin
                    total++; bad++;
                    $display("FAIL op_in_progress: go=%b busy=%b at cycle %0d, expected go=0 busy=1", go, busy, k);
                end
                return;
            end
            if (k >= 2 && k <= 65) seen = {seen[62:0], inpab};
            shift = 0; out_c = 0; done = 0; over = rbit(); under = rbit();
            if (k < resp_start) begin
                if ($urandom_range(0, 7) == 0) begin shift = 1; out_c = rbit(); end
                if (k == 40) done = 1;
            end else if (k < resp_start + nres) begin
                shift = 1;
                idx   = resp_start + nres - 1 - k;
                out_c = (idx < 32) ? rword[idx] : rbit();
            end
            if (shift) q.push_back(out_c);
            if (k == 65) check("inpab_stream", seen, op[63:0]);
            if (k == done_k) begin
                done = 1; over = rov; under = run;
                break;
            end
            @(negedge clk);
            k++;
        end
        // Result is the most recent 32 captured bits, zero-filled if fewer.
        n = q.size();
        expv = '0;
        for (int i = 0; i < 32 && i < n; i++) expv[i] = q[n - 1 - i];
        exp_q.push_back({expv, rov, run});
        @(negedge clk);
        shift = 0; out_c = 0; done = 0;
        check("go_high_in_done", go, 1);
    endtask

    initial begin : mock
        shift = 0; out_c = 0; done = 0; over = 0; under = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && go === 1'b0) run_op();
        end
    end

    initial begin : monitor
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (timeout_err === 1'b1) n_timeouts++;
            if (res_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_res_valid: result=%h with nothing pending", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e[33:2]);
                    check("res_over", res_over, e[1]);
                    check("res_under", res_under, e[0]);
                    last_result = e[33:2];
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            total++; bad++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit directed);
        wait_idle();
        check("result_hold", result, last_result);
        op_a = a; op_b = b; start = 1;
        op_q.push_back({directed, a, b});
        @(negedge clk);
        start = 0; op_a = $urandom; op_b = $urandom;
    endtask

    initial begin : stim
        reset = 1; start = 0; op_a = 0; op_b = 0;
        repeat (3) @(negedge clk);
        check("rst_go", go, 1);
        check("rst_inpab", inpab, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_result", result, 0);
        check("rst_res_over", res_over, 0);
        check("rst_res_under", res_under, 0);
        reset = 0;
        @(negedge clk);

        // Abort mid-operation with an asynchronous reset.
        expect_abort = 1;
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (19) @(negedge clk);
        #2 reset = 1;
        #1;
        check("abort_go", go, 1);
        check("abort_inpab", inpab, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        expect_abort = 0;
        check("abort_result", result, 0);
        @(negedge clk);

        issue(32'h7F7F_FFFF, 32'h7380_0000, 1'b1);
        issue(FP32_ONE, FP32_ONE, 1'b1);
        issue(32'h8000_0001, 32'h0000_0003, 1'b1);

        // A start pulse during SEND_B must be ignored.
        issue($urandom, $urandom, 1'b0);
        repeat (44) @(negedge clk);
        start = 1; op_a = $urandom; op_b = $urandom;
        @(negedge clk);
        start = 0;

        for (int i = 0; i < 10; i++) issue($urandom, $urandom, 1'b0);
        wait_idle();

`ifdef FP32_SERIAL_HOST_TIMEOUT_EN
        begin : timeout_case
            int n;
            expect_abort = 1; suppress_done = 1;
            issue(FP32_ONE, FP32_POS_INF, 1'b0);
            n = 1;
            while (timeout_err !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("timeout_latency", n, 126);
            check("timeout_go", go, 1);
            check("timeout_busy", busy, 0);
            check("timeout_res_valid", res_valid, 0);
            @(negedge clk);
            check("timeout_pulse_width", timeout_err, 0);
            expect_abort = 0; suppress_done = 0;
            check("timeout_result_hold", result, last_result);
        end
`endif

        repeat (5) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        check("pending_ops", op_q.size(), 0);
        check("timeout_count", n_timeouts, c_EXP_TIMEOUTS);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
